// File: rtl/jelly_fixed_to_float_conv.sv
// Four-stage signed fixed-point to compact float converter {sign, biased exp, frac}.
// Valid/ready stream with a user sideband; the whole pipe advances or holds as one unit.
`timescale 1ns/1ps
module jelly_fixed_to_float_conv #(
  parameter int USER_WIDTH         = 0,
  parameter int S_FIXED_INT_WIDTH  = 16,
  parameter int S_FIXED_FRAC_WIDTH = 8,
  parameter int M_FLOAT_EXP_WIDTH  = 6,
  parameter int M_FLOAT_EXP_OFFSET = (1 << (M_FLOAT_EXP_WIDTH - 1)) - 1,
  parameter int M_FLOAT_FRAC_WIDTH = 16,
  localparam int USER_BITS         = (USER_WIDTH > 0) ? USER_WIDTH : 1,
  localparam int W                 = S_FIXED_INT_WIDTH + S_FIXED_FRAC_WIDTH,
  localparam int M_FLOAT_WIDTH     = 1 + M_FLOAT_EXP_WIDTH + M_FLOAT_FRAC_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [USER_BITS-1:0]     s_user,
  input  logic [W-1:0]             s_fixed,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [USER_BITS-1:0]     m_user,
  output logic [M_FLOAT_WIDTH-1:0] m_float,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int P_WIDTH = (W > 1) ? $clog2(W) : 1;
  localparam int EXP_MAX = (1 << M_FLOAT_EXP_WIDTH) - 1;

  logic adv;
  assign adv     = cke & (~m_valid | m_ready);
  assign s_ready = adv;

  logic                          st0_valid, st0_sign;
  logic [W-1:0]                  st0_mag;
  logic [USER_BITS-1:0]          st0_user;

  logic                          st1_valid, st1_sign, st1_zero;
  logic [P_WIDTH-1:0]            st1_pos;
  logic [W-1:0]                  st1_mag;
  logic [USER_BITS-1:0]          st1_user;

  logic                          st2_valid, st2_sign, st2_zero;
  logic [P_WIDTH-1:0]            st2_pos;
  logic [M_FLOAT_FRAC_WIDTH-1:0] st2_frac;
  logic [USER_BITS-1:0]          st2_user;

  logic [P_WIDTH-1:0]            lead_pos;
  logic                          lead_zero;
  logic [P_WIDTH-1:0]            norm_shift;
  logic [M_FLOAT_FRAC_WIDTH-1:0] norm_frac;
  int                            exp_calc;
  logic [M_FLOAT_WIDTH-1:0]      float_next;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lead_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (st0_mag[i]) lead_pos = P_WIDTH'(i);
    end
    lead_zero = (st0_mag == '0);
  end

  // Drop the hidden one and left-align the remaining bits; the appended zeros
  // fill the LSBs when the stored fraction is wider than the input.
  assign norm_shift = P_WIDTH'(W - 1) - st1_pos;
  assign norm_frac  = M_FLOAT_FRAC_WIDTH'({st1_mag << norm_shift, {M_FLOAT_FRAC_WIDTH{1'b0}}} >> (W - 1));

  always_comb begin
    exp_calc   = int'(st2_pos) - S_FIXED_FRAC_WIDTH + M_FLOAT_EXP_OFFSET;
    float_next = '0;
    if (st2_zero) begin
      float_next = '0;
    end else if (exp_calc > EXP_MAX) begin
      float_next = {st2_sign, {M_FLOAT_EXP_WIDTH{1'b1}}, {M_FLOAT_FRAC_WIDTH{1'b1}}};
    end else if (exp_calc < 0) begin
      float_next = {st2_sign, {(M_FLOAT_WIDTH-1){1'b0}}};
    end else begin
      float_next = {st2_sign, M_FLOAT_EXP_WIDTH'(exp_calc), st2_frac};
    end
  end

  // Control and visible outputs: reset clears them and discards in-flight items.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
      st0_valid <= 1'b0;
      st1_valid <= 1'b0;
      st2_valid <= 1'b0;
      m_valid   <= 1'b0;
      m_float   <= '0;
      m_user    <= '0;
    end else if (adv) begin
      st0_valid <= s_valid;
      st1_valid <= st0_valid;
      st2_valid <= st1_valid;
      m_valid   <= st2_valid;
      m_float   <= float_next;
      m_user    <= st2_user;
    end
  end

  // NOTE: internal data stages carry no reset; their contents are qualified by the stage valids.
  always_ff @(posedge clk) begin
    if (adv) begin
      st0_sign <= s_fixed[W-1];
      st0_mag  <= s_fixed[W-1] ? -s_fixed : s_fixed;
      st0_user <= s_user;

      st1_sign <= st0_sign;
      st1_zero <= lead_zero;
      st1_pos  <= lead_pos;
      st1_mag  <= st0_mag;
      st1_user <= st0_user;

      st2_sign <= st1_sign;
      st2_zero <= st1_zero;
      st2_pos  <= st1_pos;
      st2_frac <= norm_frac;
      st2_user <= st1_user;
    end
  end

endmodule

// File: tb/tb_jelly_fixed_to_float_conv.sv
// Self-checking bench: directed vector tables, scoreboarded random streams,
// stall/cke/reset corner sequences, and a narrow-exponent instance for saturate/flush.
`timescale 1ns/1ps
module tb_jelly_fixed_to_float_conv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-format instance with an 8-bit sideband
  logic        cke, s_valid, s_ready, m_valid, m_ready;
  logic [7:0]  s_user, m_user;
  logic [23:0] s_fixed;
  logic [22:0] m_float;

  jelly_fixed_to_float_conv #(.USER_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_user(s_user), .s_fixed(s_fixed), .s_valid(s_valid), .s_ready(s_ready),
    .m_user(m_user), .m_float(m_float), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Narrow-exponent instance (4-bit exp, bias 7), dummy sideband
  logic        b_cke, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [0:0]  b_s_user, b_m_user;
  logic [23:0] b_s_fixed;
  logic [20:0] b_m_float;

  jelly_fixed_to_float_conv #(.M_FLOAT_EXP_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .cke(b_cke),
    .s_user(b_s_user), .s_fixed(b_s_fixed), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_user(b_m_user), .m_float(b_m_float), .m_valid(b_m_valid), .m_ready(b_m_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct { logic [22:0] flt; logic [7:0] user; } exp_t;
  typedef struct { logic [23:0] fx;  logic [22:0] flt;  } vec_t;
  typedef struct { logic [23:0] fx;  logic [20:0] flt;  } vec_b_t;

  exp_t        sb[$];
  logic        hold_pending = 1'b0;
  logic        held_valid;
  logic [22:0] held_float;
  logic [7:0]  held_user;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value = (-1)^s * 1.frac * 2^(p - 8), biased by 31, truncated fraction.
  function automatic logic [22:0] model(input logic [23:0] fx);
    longint v, mag, frac;
    int     p, e;
    logic   sgn;
    v   = longint'($signed(fx));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return '0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e    = p - 8 + 31;
    frac = ((mag - (longint'(1) << p)) << 16) >> p;
    if (e > 63) return {sgn, 6'h3F, 16'hFFFF};
    if (e < 0)  return {sgn, 22'h0};
    return {sgn, 6'(e), 16'(frac)};
  endfunction

  function automatic logic [23:0] rand_fx();
    case ($urandom % 4)
      0:       return 24'($urandom);
      1:       return 24'($urandom % 16);
      2:       case ($urandom % 3)
                 0:       return 24'h800000;
                 1:       return 24'h000000;
                 default: return 24'hFFFFFF;
               endcase
      default: return 24'($urandom >> ($urandom % 32));
    endcase
  endfunction

  // One cycle on the main instance: drive at the falling edge, sample 1 ns later.
  task automatic step(input logic v, input logic [23:0] fx, input logic [7:0] usr,
                      input logic rdy, input logic ck, output logic acc);
    exp_t e;
    s_valid = v; s_fixed = fx; s_user = usr; m_ready = rdy; cke = ck;
    #1;
    check("s_ready", s_ready, ck && (!m_valid || rdy));
    if (hold_pending) begin
      check("hold_valid", m_valid, held_valid);
      check("hold_float", m_float, held_float);
      check("hold_user",  m_user,  held_user);
    end
    acc = v && s_ready;
    if (acc) begin
      e.flt = model(fx); e.user = usr;
      sb.push_back(e);
    end
    if (m_valid && rdy && ck) begin
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        check("stream_float", m_float, e.flt);
        check("stream_user",  m_user,  e.user);
      end
    end
    hold_pending = !(ck && (!m_valid || rdy));
    held_valid = m_valid; held_float = m_float; held_user = m_user;
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while (sb.size() > 0 && n < 60) begin
      step(1'b0, 24'h0, 8'h0, 1'b1, 1'b1, acc);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Single item into an empty pipe: absent after three edges, present after the fourth.
  task automatic single(input string nm, input logic [23:0] fx, input logic [22:0] ex);
    s_valid = 1'b1; s_fixed = fx; s_user = 8'hA5; m_ready = 1'b1; cke = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_early"}, m_valid, 0);
    @(negedge clk);
    check({nm, "_valid"}, m_valid, 1);
    check({nm, "_float"}, m_float, ex);
    check({nm, "_user"},  m_user,  8'hA5);
    @(negedge clk);
    hold_pending = 1'b0;
  endtask

  task automatic single_b(input string nm, input logic [23:0] fx, input logic [20:0] ex);
    b_s_valid = 1'b1; b_s_fixed = fx;
    @(negedge clk);
    b_s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({nm, "_early"}, b_m_valid, 0);
    @(negedge clk);
    check({nm, "_valid"}, b_m_valid, 1);
    check({nm, "_float"}, b_m_float, ex);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[8];
    vec_b_t vecs_b[5];
    logic   acc;
    logic [23:0] b2b[8];
    int     idx, cyc;

    vecs[0] = '{24'h000100, 23'h1F0000};   //  1.0
    vecs[1] = '{24'hFFFE80, 23'h5F8000};   // -1.5
    vecs[2] = '{24'h000000, 23'h000000};   //  zero
    vecs[3] = '{24'h000001, 23'h170000};   //  smallest positive
    vecs[4] = '{24'h800000, 23'h6E0000};   //  most negative
    vecs[5] = '{24'h7FFFFF, 23'h2DFFFF};   //  most positive, frac truncated
    vecs[6] = '{24'hFFFFFF, 23'h570000};   // -1/256
    vecs[7] = '{24'h000003, 23'h188000};

    vecs_b[0] = '{24'h7FFFFF, 21'h0FFFFF};  // saturate
    vecs_b[1] = '{24'h000001, 21'h000000};  // flush
    vecs_b[2] = '{24'h800000, 21'h1FFFFF};  // saturate, sign kept
    vecs_b[3] = '{24'hFFFFFF, 21'h100000};  // flush, sign kept
    vecs_b[4] = '{24'h000100, 21'h070000};  // 1.0 with bias 7

    reset = 1'b1;
    cke = 1'b1; s_valid = 1'b0; s_fixed = '0; s_user = '0; m_ready = 1'b1;
    b_cke = 1'b1; b_s_valid = 1'b0; b_s_fixed = '0; b_s_user = '0; b_m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_float", m_float, 0);
    check("reset_m_user",  m_user,  0);
    check("reset_b_valid", b_m_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) single($sformatf("vec%0d", i), vecs[i].fx, vecs[i].flt);
    for (int i = 0; i < 5; i++) single_b($sformatf("vecb%0d", i), vecs_b[i].fx, vecs_b[i].flt);

    // Eight values back to back, m_ready pattern 1,0,0,1,0,0,...
    for (int i = 0; i < 8; i++) b2b[i] = rand_fx();
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      step(1'b1, b2b[idx], 8'(idx), (cyc % 3) == 0, 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    if (idx != 8) check("b2b_accept_timeout", idx, 8);
    drain();

    // cke low for five cycles in the middle of a stream
    for (int i = 0; i < 20; i++)
      step(1'b1, rand_fx(), 8'(i), 1'(i % 2), !(i >= 6 && i < 11), acc);
    drain();

    // Randomized stream
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 4 != 0), rand_fx(), 8'($urandom), 1'($urandom % 3 != 0),
           1'($urandom % 8 != 0), acc);
    drain();

    // Reset with a stalled, full pipe
    for (int i = 0; i < 5; i++) step(1'b1, rand_fx(), 8'(i), 1'b0, 1'b1, acc);
    s_valid = 1'b0;
    check("pre_reset_valid", m_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("reset_async_valid", m_valid, 0);
    check("reset_async_float", m_float, 0);
    check("reset_async_user",  m_user,  0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 24'h0, 8'h0, 1'b1, 1'b1, acc);
      check("no_stale", m_valid, 0);
    end
    single("post_reset", 24'h000100, 23'h1F0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
